crc8_checker: RTL and testbench

- Receive-side counterpart of CRC8_calculator. Takes a frame of bytes followed by one CRC byte and recomputes the CRC bit-serially, using the same polynomial and the same bit ordering as the calculator.
- Compares the recomputed value against the received CRC byte and reports pass or fail per frame. A saturating error counter is exposed for control_logic self-test reporting.

---
 rtl/crc8_pkg.sv | 25 ++
 rtl/crc8_bit_step.sv | 15 +
 rtl/crc8_checker.sv | 112 +++++++++++
 tb/tb_crc8_checker.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/crc8_pkg.sv
// Shared CRC-8 definitions for the calculator and the checker: the generator
// polynomial, the checker FSM encoding and the single-bit register update.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'hD1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } crc_state_e;

  // Conditional XOR with the polynomial happens before the shift, so the new
  // bit always lands in r[0] untouched.
  function automatic logic [7:0] crc8_step(
    input logic [7:0] r,
    input logic       din,
    input logic [7:0] poly = CRC8_POLY
  );
    logic [7:0] t;
    t = r[7] ? (r ^ poly) : r;
    return {t[6:0], din};
  endfunction

endpackage

// File: rtl/crc8_bit_step.sv
// Combinational one-bit CRC-8 update, shared by the calculator and the checker
// so both ends of the link use identical next-state logic.
module crc8_bit_step
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY = CRC8_POLY
) (
  input  logic [7:0] crc,
  input  logic       din,
  output logic [7:0] next_crc
);

  assign next_crc = crc8_step(crc, din, POLY);

endmodule

// File: rtl/crc8_checker.sv
// Receive-side CRC-8 checker: shifts payload bytes MSB first through the CRC
// register, then compares the trailing CRC byte and counts failed frames.
module crc8_checker
  import crc8_pkg::*;
#(
  parameter logic [7:0] POLY  = CRC8_POLY,
  parameter int         ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       data,
  input  logic             new_data,
  input  logic             last,
  output logic             busy,
  output logic             done,
  output logic             crc_ok,
  output logic [7:0]       crc_calc,
  output logic [ERR_W-1:0] err_count,
  output logic             overrun
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  crc_state_e state;
  logic       nd_prev;
  logic [2:0] bit_cnt;
  logic [7:0] byte_q;
  logic [7:0] r;
  logic [7:0] r_next;
  logic       rise;
  logic       accept;
  logic       mismatch;

  assign rise     = new_data & ~nd_prev;
  assign accept   = rise & (state == IDLE);
  assign mismatch = (byte_q != r);
  assign crc_calc = r;

  crc8_bit_step #(
    .POLY (POLY)
  ) u_bit_step (
    .crc      (r),
    .din      (byte_q[bit_cnt]),
    .next_crc (r_next)
  );

  // NOTE: every register here uses <= so all updates see the pre-edge values,
  // which is what makes the busy-based overrun test line up with the FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      nd_prev   <= new_data;  // a strobe held through reset is not an edge
      bit_cnt   <= '0;
      byte_q    <= '0;
      r         <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      crc_ok    <= 1'b0;
      err_count <= '0;
      overrun   <= 1'b0;
    end else begin
      nd_prev <= new_data;
      done    <= 1'b0;

      // A strobe rising on the edge where busy falls still counts as overrun.
      if (rise && busy) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (accept) begin
            byte_q <= data;
            busy   <= 1'b1;
            if (last) begin
              state <= CHECK;
            end else begin
              state   <= SHIFT;
              bit_cnt <= 3'd7;
            end
          end
        end

        SHIFT: begin
          r       <= r_next;
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        CHECK: begin
          done   <= 1'b1;
          busy   <= 1'b0;
          crc_ok <= ~mismatch;
          if (mismatch && (err_count != ERR_MAX)) err_count <= err_count + 1'b1;
          r      <= '0;
          state  <= IDLE;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  a_done_busy_exclusive : assert property (
    @(posedge clk) disable iff (!rst) !(done && busy)
  );

endmodule

// File: tb/tb_crc8_checker.sv
// Randomised self-checking bench for crc8_checker against a frame-level
// CRC-8 reference model.
module tb_crc8_checker;

  localparam logic [7:0] POLY = 8'hD1;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] data = '0;
  logic       new_data = 1'b0;
  logic       last = 1'b0;
  logic       busy;
  logic       done;
  logic       crc_ok;
  logic [7:0] crc_calc;
  logic [3:0] err_count;
  logic       overrun;

  int errors = 0;
  int checks = 0;
  int exp_err = 0;
  logic [7:0] payload[$];

  crc8_checker #(
    .POLY  (POLY),
    .ERR_W (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .data      (data),
    .new_data  (new_data),
    .last      (last),
    .busy      (busy),
    .done      (done),
    .crc_ok    (crc_ok),
    .crc_calc  (crc_calc),
    .err_count (err_count),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got=hang exp=finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: polynomial division of the first n payload bytes, MSB first,
  // starting from zero.
  function automatic logic [7:0] ref_crc(input int n);
    int acc;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        if (acc >= 128) acc = acc ^ int'(POLY);
        acc = ((acc * 2) + ((int'(payload[i]) >> b) & 1)) % 256;
      end
    end
    return 8'(acc);
  endfunction

  // Drive one strobe and wait for busy to drop; returns busy cycle count.
  task automatic send_byte(input logic [7:0] d, input logic l, output int cyc);
    @(negedge clk);
    data     = d;
    last     = l;
    new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      @(negedge clk);
    end
  endtask

  // Sends the current payload queue plus a CRC byte and checks the verdict.
  task automatic send_frame(input logic [7:0] crc_byte, input string tag);
    int   cyc;
    logic good;
    for (int i = 0; i < payload.size(); i++) begin
      send_byte(payload[i], 1'b0, cyc);
      check({tag, ".busy_cycles"}, 32'(cyc), 32'd8);
      check({tag, ".crc_calc"}, 32'(crc_calc), 32'(ref_crc(i + 1)));
      check({tag, ".no_done"}, 32'(done), 32'd0);
    end
    good = (crc_byte == ref_crc(payload.size()));
    if (!good && exp_err < 15) exp_err++;
    send_byte(crc_byte, 1'b1, cyc);
    check({tag, ".check_cycles"}, 32'(cyc), 32'd1);
    check({tag, ".done"}, 32'(done), 32'd1);
    check({tag, ".crc_ok"}, 32'(crc_ok), 32'(good));
    check({tag, ".err_count"}, 32'(err_count), 32'(exp_err));
    check({tag, ".crc_cleared"}, 32'(crc_calc), 32'd0);
    @(negedge clk);
    check({tag, ".done_one_cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc;
    int cnt;
    logic [7:0] b;

    repeat (3) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.done", 32'(done), 32'd0);
    check("reset.crc_ok", 32'(crc_ok), 32'd0);
    check("reset.crc_calc", 32'(crc_calc), 32'd0);
    check("reset.err_count", 32'(err_count), 32'd0);
    check("reset.overrun", 32'(overrun), 32'd0);
    rst = 1'b1;

    payload = '{8'h01};
    check("model.01", 32'(ref_crc(1)), 32'h01);
    send_frame(8'h01, "f01");

    payload = '{8'h80, 8'h00};
    check("model.8000", 32'(ref_crc(2)), 32'hD0);
    send_frame(8'hD0, "f8000_ok");
    send_frame(8'hD1, "f8000_bad");

    payload = {};
    send_frame(8'h00, "empty_ok");
    send_frame(8'h5A, "empty_bad");

    // Strobe held high across many byte times is a single accept.
    @(negedge clk);
    data = 8'h80; last = 1'b0; new_data = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) cnt++;
    end
    new_data = 1'b0;
    check("held.busy_cycles", 32'(cnt), 32'd8);
    check("held.crc_calc", 32'(crc_calc), 32'h80);
    check("held.overrun", 32'(overrun), 32'd0);
    payload = {};
    send_byte(8'h80, 1'b1, cyc);
    check("held.crc_ok", 32'(crc_ok), 32'd1);

    // Second edge during SHIFT is dropped and flags overrun.
    @(negedge clk);
    data = 8'h80; last = 1'b0; new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0;
    @(negedge clk);
    data = 8'hFF; last = 1'b1; new_data = 1'b1;
    @(negedge clk);
    new_data = 1'b0; data = 8'h00; last = 1'b0;
    cnt = 0;
    while (busy && cnt < 50) begin
      cnt++;
      @(negedge clk);
    end
    check("ovr.busy_done", 32'(busy), 32'd0);
    check("ovr.overrun", 32'(overrun), 32'd1);
    check("ovr.crc_calc", 32'(crc_calc), 32'h80);
    check("ovr.no_done", 32'(done), 32'd0);
    payload = '{8'h80};
    send_byte(8'h80, 1'b1, cyc);
    check("ovr.crc_ok", 32'(crc_ok), 32'd1);
    check("ovr.sticky", 32'(overrun), 32'd1);

    // Random frames, roughly half with a corrupted CRC byte.
    for (int f = 0; f < 20; f++) begin
      payload = {};
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) payload.push_back(8'($urandom));
      b = ref_crc(payload.size());
      if ($urandom_range(0, 1) == 1) b = b ^ 8'($urandom_range(1, 255));
      send_frame(b, $sformatf("rnd%0d", f));
    end

    // Reset in the middle of a byte, with the strobe still held.
    @(negedge clk);
    data = 8'h5A; last = 1'b0; new_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.done", 32'(done), 32'd0);
    check("midrst.crc_ok", 32'(crc_ok), 32'd0);
    check("midrst.crc_calc", 32'(crc_calc), 32'd0);
    check("midrst.err_count", 32'(err_count), 32'd0);
    check("midrst.overrun", 32'(overrun), 32'd0);
    rst = 1'b1;
    exp_err = 0;
    cnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (busy || done) cnt++;
    end
    new_data = 1'b0;
    check("midrst.no_activity", 32'(cnt), 32'd0);

    payload = '{8'h01};
    send_frame(8'h01, "postrst");

    for (int f = 0; f < 16; f++) begin
      payload = {};
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) payload.push_back(8'($urandom));
      send_frame(ref_crc(payload.size()) ^ 8'($urandom_range(1, 255)), $sformatf("sat%0d", f));
    end
    check("sat.final", 32'(err_count), 32'hF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
